// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time from instruction
// memory and holds it for the datapath until accepted; misaligned targets latch a fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  output logic        IMEM_req_valid,
  input  logic        IMEM_req_ready,
  output logic [31:0] IMEM_req_addr,
  input  logic        IMEM_resp_valid,
  input  logic [31:0] IMEM_resp_data,
  output logic        FETCH_valid,
  input  logic        FETCH_ready,
  output logic [31:0] FETCH_instruction,
  output logic [31:0] FETCH_PC,
  input  logic [31:0] new_PC,
  output logic        FETCH_fault,
  output logic [31:0] FETCH_retired,
  output logic [2:0]  debug_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // once raised, valid (and its payload) holds until that edge.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] retired;
  logic        req_valid;
  logic        fetch_valid;
  logic        fault;

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      retired     <= 32'd0;
      req_valid   <= 1'b0;
      fetch_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state     <= REQ;
          req_valid <= 1'b1;
        end
        REQ: begin
          if (IMEM_req_ready) begin
            state     <= WAIT;
            req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (IMEM_resp_valid) begin
            instr       <= IMEM_resp_data;
            state       <= HOLD;
            fetch_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (FETCH_ready) begin
            // The target loads even when misaligned so the fault shows where it went.
            pc          <= new_PC;
            retired     <= retired + 32'd1;
            fetch_valid <= 1'b0;
            if (new_PC[1:0] == 2'b00) begin
              state     <= REQ;
              req_valid <= 1'b1;
            end else begin
              state <= FAULT;
              fault <= 1'b1;
            end
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state       <= IDLE;
          req_valid   <= 1'b0;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

  assign IMEM_req_valid    = req_valid;
  assign IMEM_req_addr     = pc;
  assign FETCH_valid       = fetch_valid;
  assign FETCH_instruction = instr;
  assign FETCH_PC          = pc;
  assign FETCH_fault       = fault;
  assign FETCH_retired     = retired;
  assign debug_state       = state;

endmodule
